fly_sprite_blitter: RTL and testbench



---
 rtl/fly_sprite_blitter.sv | 184 ++++++++++++++++++
 tb/tb_fly_sprite_blitter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fly_sprite_blitter.sv
// Fly sprite blitter: draws or erases the SPRITE_W x SPRITE_H fly sprite at one of
// four hole positions, one pixel per clock, into the VGA adapter plot interface.
//
// Ports:
//   clock, resetn        system clock, synchronous active-low reset
//   start                request pulse, only sampled while idle
//   location, erase,     job parameters, latched when start is accepted
//   y_offset
//   busy, done           job in progress / one-cycle completion pulse
//   rom_addr, rom_data   sprite ROM port (data valid one cycle after address)
//   x, y, colour, plot   pixel output to the VGA adapter
module fly_sprite_blitter #(
  parameter int unsigned SPRITE_W      = 16,
  parameter int unsigned SPRITE_H      = 16,
  parameter int unsigned X_BASE        = 40,
  parameter int unsigned X_STEP        = 70,
  parameter int unsigned Y_BASE        = 100,
  parameter logic [2:0]  BG_COLOUR     = 3'b000,
  parameter logic [2:0]  TRANSP_COLOUR = 3'b101,
  parameter int unsigned SCREEN_W      = 320,
  parameter int unsigned SCREEN_H      = 240
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] location,
  input  logic       erase,
  input  logic [7:0] y_offset,
  output logic       busy,
  output logic       done,
  output logic [7:0] rom_addr,
  input  logic [2:0] rom_data,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam int unsigned ColW  = $clog2(SPRITE_W);
  localparam int unsigned RowW  = $clog2(SPRITE_H);
  localparam int unsigned AddrW = ColW + RowW;

  localparam logic [9:0] ScreenW = 10'(SCREEN_W);
  localparam logic [9:0] ScreenH = 10'(SCREEN_H);

  typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} state_e;

  state_e state_q, state_d;

  // Scan counter doubles as the ROM address: low bits are the column, high bits the row.
  logic [AddrW-1:0] addr_q, addr_d;
  logic             last_addr;
  logic             accept;

  // Job parameters folded into the box origin at accept time.
  logic [9:0] x_org_q, x_org_d;
  logic [9:0] y_org_q, y_org_d;
  logic       erase_q, erase_d;

  // Pixel stage: one cycle behind the address, aligned with rom_data.
  logic [8:0] x_q;
  logic [7:0] y_q;
  logic       pix_q;
  logic       clip_q;
  logic [2:0] colour_q;

  logic [ColW-1:0] col;
  logic [RowW-1:0] row;
  logic [9:0]      x_next;
  logic [9:0]      y_next;
  logic            clip_next;
  logic [2:0]      colour_live;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_addr = (addr_q == '1);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          accept  = 1'b1;
        end
      end
      StScan: begin
        if (last_addr) begin
          state_d = StFlush;
        end
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Address counter and latched job parameters
  // -------------------------------------------------------------------------
  always_comb begin
    addr_d  = addr_q;
    x_org_d = x_org_q;
    y_org_d = y_org_q;
    erase_d = erase_q;
    if (accept) begin
      addr_d  = '0;
      x_org_d = 10'(X_BASE) + 10'(location) * 10'(X_STEP);
      y_org_d = 10'(Y_BASE) + 10'(y_offset);
      erase_d = erase;
    end else if (state_q == StScan && !last_addr) begin
      addr_d = addr_q + 1'b1;
    end
  end

  assign col = addr_q[ColW-1:0];
  assign row = addr_q[AddrW-1:ColW];

  assign x_next    = x_org_q + 10'(col);
  assign y_next    = y_org_q + 10'(row);
  assign clip_next = (x_next >= ScreenW) || (y_next >= ScreenH);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q  <= '0;
      x_org_q <= '0;
      y_org_q <= '0;
      erase_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      x_org_q <= x_org_d;
      y_org_q <= y_org_d;
      erase_q <= erase_d;
    end
  end

  // -------------------------------------------------------------------------
  // Pixel stage
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_q      <= '0;
      y_q      <= '0;
      pix_q    <= 1'b0;
      clip_q   <= 1'b0;
      colour_q <= '0;
    end else begin
      pix_q <= (state_q == StScan);
      if (state_q == StScan) begin
        x_q    <= x_next[8:0];
        y_q    <= y_next[7:0];
        clip_q <= clip_next;
      end
      // Remember the last presented colour so it holds between jobs.
      if (pix_q) begin
        colour_q <= colour_live;
      end
    end
  end

  // ROM data lands in the same cycle as its pixel slot, so colour and the
  // transparency test are taken straight from rom_data rather than re-registered.
  assign colour_live = erase_q ? BG_COLOUR : rom_data;

  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    rom_addr = 8'(addr_q);
    x        = x_q;
    y        = y_q;
    colour   = pix_q ? colour_live : colour_q;
    plot     = pix_q && !clip_q && (erase_q || (rom_data != TRANSP_COLOUR));
  end

endmodule

// File: tb/tb_fly_sprite_blitter.sv
// Self-checking bench for fly_sprite_blitter: table of directed jobs with expected
// spans/plot counts, per-cycle comparison against a pixel-list reference model,
// hand-written handshake/reset sequences and randomized jobs.
module tb_fly_sprite_blitter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] location;
  logic       erase;
  logic [7:0] y_offset;
  logic       busy;
  logic       done;
  logic [7:0] rom_addr;
  logic [2:0] rom_data = 3'b000;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       plot;

  int total = 0;
  int bad   = 0;

  logic [2:0] rom_mem [256];

  always #5 clock = ~clock;

  // Sprite ROM with one cycle of read latency.
  always @(posedge clock) rom_data <= rom_mem[rom_addr];

  fly_sprite_blitter dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .location (location),
    .erase    (erase),
    .y_offset (y_offset),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: pixel n of the box, straight from the drawing rules.
  function automatic int ref_x10(input int loc, input int n);
    return 40 + loc * 70 + n % 16;
  endfunction

  function automatic int ref_y10(input int yoff, input int n);
    return 100 + yoff + n / 16;
  endfunction

  function automatic int ref_colour(input bit er, input int n);
    return er ? 0 : int'(rom_mem[n]);
  endfunction

  function automatic int ref_plot(input int loc, input bit er, input int yoff, input int n);
    return (ref_x10(loc, n) < 320 && ref_y10(yoff, n) < 240 &&
            (er || rom_mem[n] != 3'b101)) ? 1 : 0;
  endfunction

  // Runs one job from accept (edge k) through the IDLE cycle k+259, checking every cycle.
  // hold: keep start high; inj: extra start pulses at k+10 and k+258; chain: start again
  // at k+259 and check the follow-on job's busy/done timing.
  task automatic run_job(input logic [1:0] loc, input logic er, input logic [7:0] yoff,
                         input bit hold, input bit inj, input bit chain,
                         output int plots, output int xmin, output int xmax,
                         output int ymin, output int ymax);
    int n;
    int w;
    int li;
    int yi;
    plots = 0; xmin = 1000; xmax = -1; ymin = 1000; ymax = -1;
    li = int'(loc);
    yi = int'(yoff);
    @(negedge clock);
    start = 1'b1; location = loc; erase = er; y_offset = yoff;
    @(posedge clock);
    for (int c = 1; c <= 259; c++) begin
      @(negedge clock);
      start = hold || (inj && (c == 10 || c == 258));
      if (c == 5) begin
        location = 2'($urandom); erase = 1'($urandom); y_offset = 8'($urandom);
      end
      chk($sformatf("busy c=%0d", c), 32'(busy), (c <= 258) ? 1 : 0);
      chk($sformatf("done c=%0d", c), 32'(done), (c == 258) ? 1 : 0);
      if (c <= 256) chk($sformatf("rom_addr c=%0d", c), 32'(rom_addr), c - 1);
      if (c >= 2 && c <= 257) begin
        n = c - 2;
        chk($sformatf("x n=%0d", n), 32'(x), ref_x10(li, n) % 512);
        chk($sformatf("y n=%0d", n), 32'(y), ref_y10(yi, n) % 256);
        chk($sformatf("colour n=%0d", n), 32'(colour), ref_colour(er, n));
        chk($sformatf("plot n=%0d", n), 32'(plot), ref_plot(li, er, yi, n));
        if (plot === 1'b1) plots++;
        if (int'(x) < xmin) xmin = int'(x);
        if (int'(x) > xmax) xmax = int'(x);
        if (int'(y) < ymin) ymin = int'(y);
        if (int'(y) > ymax) ymax = int'(y);
      end else begin
        chk($sformatf("plot idle c=%0d", c), 32'(plot), 0);
      end
      if (c == 259) begin
        chk("x hold", 32'(x), ref_x10(li, 255) % 512);
        chk("y hold", 32'(y), ref_y10(yi, 255) % 256);
        chk("colour hold", 32'(colour), ref_colour(er, 255));
      end
    end
    if (chain) begin
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      chk("chain busy k+260", 32'(busy), 1);
      w = 1;
      while (done !== 1'b1 && w < 300) begin
        @(negedge clock);
        w++;
      end
      chk("chain done latency", w, 258);
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [1:0] loc;
    logic       er;
    logic [7:0] yoff;
    int         plots;
    int         xmin;
    int         xmax;
    int         ymin;
    int         ymax;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   p, x0, x1, y0, y1;
    int   exp_plots;
    bit   seen_done, seen_busy, seen_plot;
    logic [1:0] rl;
    logic       re;
    logic [7:0] ry;

    vecs[0] = '{2'd0, 1'b1, 8'd0,   256,  40,  55, 100, 115};
    vecs[1] = '{2'd3, 1'b0, 8'd5,   224, 250, 265, 105, 120};
    vecs[2] = '{2'd1, 1'b1, 8'd130, 160, 110, 125, 230, 245};
    vecs[3] = '{2'd2, 1'b0, 8'd0,   224, 180, 195, 100, 115};
    vecs[4] = '{2'd3, 1'b1, 8'd200,   0, 250, 265,  44,  59};

    for (int i = 0; i < 256; i++) rom_mem[i] = 3'(i);

    resetn = 1'b0; start = 1'b1; location = 2'd0; erase = 1'b0; y_offset = 8'd0;
    repeat (3) @(negedge clock);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset plot", 32'(plot), 0);
    chk("reset x", 32'(x), 0);
    chk("reset y", 32'(y), 0);
    chk("reset colour", 32'(colour), 0);
    chk("reset rom_addr", 32'(rom_addr), 0);
    resetn = 1'b1; start = 1'b0;

    // Directed jobs with spans and plot counts worked out by hand.
    for (int v = 0; v < 5; v++) begin
      run_job(vecs[v].loc, vecs[v].er, vecs[v].yoff, 1'b0, 1'b0, 1'b0, p, x0, x1, y0, y1);
      chk($sformatf("vec%0d plots", v), p, vecs[v].plots);
      chk($sformatf("vec%0d xmin", v), x0, vecs[v].xmin);
      chk($sformatf("vec%0d xmax", v), x1, vecs[v].xmax);
      chk($sformatf("vec%0d ymin", v), y0, vecs[v].ymin);
      chk($sformatf("vec%0d ymax", v), y1, vecs[v].ymax);
    end

    // Start pulses while busy are ignored; start right after done is accepted.
    run_job(2'd1, 1'b0, 8'd20, 1'b0, 1'b1, 1'b1, p, x0, x1, y0, y1);
    // Start held high: back-to-back jobs with one idle cycle between.
    run_job(2'd2, 1'b1, 8'd0, 1'b1, 1'b0, 1'b1, p, x0, x1, y0, y1);

    // Reset mid-scan: abandon job, no done, no plots.
    @(negedge clock);
    start = 1'b1; location = 2'd2; erase = 1'b0; y_offset = 8'd10;
    @(posedge clock);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c == 100) resetn = 1'b0;
    end
    @(negedge clock);
    chk("midreset plot", 32'(plot), 0);
    chk("midreset busy", 32'(busy), 0);
    chk("midreset done", 32'(done), 0);
    chk("midreset rom_addr", 32'(rom_addr), 0);
    chk("midreset x", 32'(x), 0);
    chk("midreset colour", 32'(colour), 0);
    resetn = 1'b1;
    seen_done = 0; seen_busy = 0; seen_plot = 0;
    repeat (300) begin
      @(negedge clock);
      if (done !== 1'b0) seen_done = 1;
      if (busy !== 1'b0) seen_busy = 1;
      if (plot !== 1'b0) seen_plot = 1;
    end
    chk("after reset no done", 32'(seen_done), 0);
    chk("after reset no busy", 32'(seen_busy), 0);
    chk("after reset no plot", 32'(seen_plot), 0);

    // Randomized jobs against the reference model.
    for (int i = 0; i < 256; i++) rom_mem[i] = 3'($urandom);
    for (int j = 0; j < 6; j++) begin
      rl = 2'($urandom);
      re = 1'($urandom);
      ry = 8'($urandom);
      exp_plots = 0;
      for (int n = 0; n < 256; n++) exp_plots += ref_plot(int'(rl), re, int'(ry), n);
      run_job(rl, re, ry, 1'b0, 1'b0, 1'b0, p, x0, x1, y0, y1);
      chk($sformatf("rand%0d plots", j), p, exp_plots);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
